// File: rtl/tpmem_pkg.sv
// Shared constants, FSM state type and lane-slice helper for the transpose-memory row feeder.
// TPFEED_FLUSH_EN adds the PAD state used to flush a partial block.
package tpmem_pkg;

  localparam int N     = 16;
  localparam int LOG2N = 4;

`ifdef TPFEED_FLUSH_EN
  typedef enum logic [1:0] {FILL, LAST, DRAIN, PAD} feed_state_t;
`else
  typedef enum logic [1:0] {FILL, LAST, DRAIN} feed_state_t;
`endif

  // Lane 0 sits in the most significant slice of the packed row.
  function automatic int lane_lo(input logic [LOG2N-1:0] lane, input int bw);
    return (N - 1 - int'(lane)) * bw;
  endfunction

endpackage

// File: rtl/tpmem_row_feeder_if.sv
// Upstream sample handshake and transpose-memory row-write bus of the row feeder.
// With TPFEED_FLUSH_EN the bus also carries i_flush.
interface tpmem_row_feeder_if
  import tpmem_pkg::*;
#(parameter int BW = 8);

  logic                 i_valid;
  logic [BW-1:0]        i_sample;
`ifdef TPFEED_FLUSH_EN
  logic                 i_flush;
`endif
  logic                 o_ready;
  logic [N*BW-1:0]      o_row;
  logic                 o_row_en;
  logic [LOG2N-1:0]     o_row_idx;

`ifdef TPFEED_FLUSH_EN
  modport master (output i_valid, i_sample, i_flush,
                  input  o_ready, o_row, o_row_en, o_row_idx);
  modport slave  (input  i_valid, i_sample, i_flush,
                  output o_ready, o_row, o_row_en, o_row_idx);
`else
  modport master (output i_valid, i_sample,
                  input  o_ready, o_row, o_row_en, o_row_idx);
  modport slave  (input  i_valid, i_sample,
                  output o_ready, o_row, o_row_en, o_row_idx);
`endif

endinterface

// File: rtl/tpmem_row_packer.sv
// Packs accepted samples into a 16-lane row and issues it as a registered one-cycle write.
// force_issue (driven only when TPFEED_FLUSH_EN is defined) issues the partial row early.
module tpmem_row_packer
  import tpmem_pkg::*;
#(parameter int BW = 8)
(
  input  logic                 i_clk,
  input  logic                 i_Reset,
  input  logic                 accept,
  input  logic [BW-1:0]        sample,
  input  logic                 force_issue,
  output logic [N*BW-1:0]      row,
  output logic                 row_en,
  output logic [LOG2N-1:0]     lane
);

  logic [N*BW-1:0] pack_q;
  logic [N*BW-1:0] merged;
  logic            wrap;

  always_comb begin
    merged = pack_q;
    if (accept) merged[lane_lo(lane, BW) +: BW] = sample;
  end

  assign wrap = (accept && lane == LOG2N'(N-1)) || force_issue;

  // Pack register is cleared on each issue so unfilled lanes of a flushed row read as zero.
  always_ff @(posedge i_clk or negedge i_Reset) begin
    if (!i_Reset) begin
      pack_q <= '0;
      row    <= '0;
      row_en <= 1'b0;
      lane   <= '0;
    end else begin
      row_en <= wrap;
      if (wrap) begin
        row    <= merged;
        pack_q <= '0;
        lane   <= '0;
      end else if (accept) begin
        pack_q <= merged;
        lane   <= lane + LOG2N'(1);
      end
    end
  end

endmodule

// File: rtl/tpmem_row_feeder.sv
// Write-side sequencer for the 16x16 transpose memory: 16 row writes per block, then a 16-cycle drain.
// Define TPFEED_FLUSH_EN to add i_flush, which zero-pads and issues a partial block.
module tpmem_row_feeder
  import tpmem_pkg::*;
#(parameter int BW = 8)
(
  input  logic               i_clk,
  input  logic               i_Reset,
  tpmem_row_feeder_if.slave  bus
);

  feed_state_t        state, state_next;
  logic [LOG2N-1:0]   row_cnt;
  logic [LOG2N-1:0]   drain_cnt;
  logic [LOG2N-1:0]   lane;
  logic [LOG2N-1:0]   row_fill;
  logic               ready_q;
  logic               accept;
  logic               force_issue;
  logic               row_en;
  logic [N*BW-1:0]    row;

  assign accept = bus.i_valid && ready_q;
  // row_cnt only steps at the end of a pulse, so the row being filled is one ahead during it.
  assign row_fill = row_cnt + LOG2N'(row_en);

  tpmem_row_packer #(.BW(BW)) u_packer (
    .i_clk       (i_clk),
    .i_Reset     (i_Reset),
    .accept      (accept),
    .sample      (bus.i_sample),
    .force_issue (force_issue),
    .row         (row),
    .row_en      (row_en),
    .lane        (lane)
  );

  always_ff @(posedge i_clk or negedge i_Reset) begin
    if (!i_Reset) state <= FILL;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    force_issue = 1'b0;
    case (state)
      FILL: begin
`ifdef TPFEED_FLUSH_EN
        if (bus.i_flush && ready_q && !(lane == '0 && !accept && row_fill == '0)) begin
          force_issue = 1'b1;
          state_next  = (row_fill == LOG2N'(N-1)) ? LAST : PAD;
        end else
`endif
        if (accept && lane == LOG2N'(N-1) && row_fill == LOG2N'(N-1))
          state_next = LAST;
      end
`ifdef TPFEED_FLUSH_EN
      PAD: begin
        force_issue = 1'b1;
        if (row_cnt == LOG2N'(N-2)) state_next = LAST;
      end
`endif
      LAST:    state_next = DRAIN;
      DRAIN:   if (drain_cnt == LOG2N'(N-1)) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Ready is registered from the next state so it stays low through reset and rises one edge later.
  always_ff @(posedge i_clk or negedge i_Reset) begin
    if (!i_Reset) begin
      ready_q   <= 1'b0;
      row_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      ready_q   <= (state_next == FILL);
      row_cnt   <= row_cnt + LOG2N'(row_en);
      drain_cnt <= (state == DRAIN) ? drain_cnt + LOG2N'(1) : '0;
    end
  end

  assign bus.o_ready   = ready_q;
  assign bus.o_row     = row;
  assign bus.o_row_en  = row_en;
  assign bus.o_row_idx = row_cnt;

endmodule

// File: tb/tb_tpmem_row_feeder.sv
// Self-checking bench for tpmem_row_feeder; the TPFEED_FLUSH_EN build adds a flush sequence.
module tb_tpmem_row_feeder;
  import tpmem_pkg::*;

  localparam int BW = 8;
  localparam int RW = N * BW;
  localparam int NV = 4;

  typedef struct {
    logic [7:0]    base;
    bit            gaps;
    int            probe;
    logic [RW-1:0] exp_row;
  } vec_t;

  logic i_clk   = 1'b0;
  logic i_Reset = 1'b0;
  int   cyc     = 0;
  int   nvec    = 0;
  int   nfail   = 0;

  vec_t          vec [NV];
  int            pulse_cyc [$];
  logic [RW-1:0] pulse_row [$];
  logic [3:0]    pulse_idx [$];
  bit            ready_at [int];

  tpmem_row_feeder_if #(.BW(BW)) bus ();

  tpmem_row_feeder #(.BW(BW)) dut (
    .i_clk   (i_clk),
    .i_Reset (i_Reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    ready_at[cyc] = bus.o_ready;
    if (bus.o_row_en) begin
      pulse_cyc.push_back(cyc);
      pulse_row.push_back(bus.o_row);
      pulse_idx.push_back(bus.o_row_idx);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, nvec=%0d", nvec);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [RW-1:0] model_row(input logic [7:0] base, input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[(N-1-k)*BW +: BW] = base + 8'(16*r + k);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Streams count samples base, base+1, ...; presents 0xAA whenever o_ready is low.
  task automatic applyStimulus(input logic [7:0] base, input bit gaps, input int count);
    int sent = 0;
    int budget = 0;
    while (sent < count && budget < 4000) begin
      @(negedge i_clk);
      budget++;
      bus.i_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.i_sample = bus.o_ready ? (base + 8'(sent)) : 8'hAA;
      if (bus.i_valid && bus.o_ready) sent++;
    end
    checkOutput("stream_accepted", RW'(sent), RW'(count));
  endtask

  task automatic waitReady();
    int budget = 0;
    while (!bus.o_ready && budget < 200) begin
      @(negedge i_clk);
      budget++;
    end
    checkOutput("ready_return", RW'(bus.o_ready), RW'(1));
    @(negedge i_clk);
  endtask

  task automatic doReset();
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    i_Reset = 1'b0;
    repeat (3) @(negedge i_clk);
    pulse_cyc.delete();
    pulse_row.delete();
    pulse_idx.delete();
    i_Reset = 1'b1;
  endtask

  task automatic checkDrain(input string name, input int t);
    int lows = 0;
    for (int k = 0; k <= 16; k++)
      if (ready_at.exists(t + k) && !ready_at[t + k]) lows++;
    checkOutput({name, "_drain_low"}, RW'(lows), RW'(17));
    checkOutput({name, "_ready_back"},
                RW'(ready_at.exists(t + 17) ? ready_at[t + 17] : 1'b0), RW'(1));
  endtask

  initial begin
    int p;
    bus.i_valid  = 1'b0;
    bus.i_sample = '0;
`ifdef TPFEED_FLUSH_EN
    bus.i_flush  = 1'b0;
`endif
    vec[0] = '{8'h00, 1'b0, 0,  128'h000102030405060708090A0B0C0D0E0F};
    vec[1] = '{8'h00, 1'b1, 15, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF};
    vec[2] = '{8'h80, 1'b0, 8,  128'h000102030405060708090A0B0C0D0E0F};
    vec[3] = '{8'h37, 1'b0, 1,  128'h4748494A4B4C4D4E4F50515253545556};

    repeat (3) @(negedge i_clk);
    checkOutput("rst_ready",   RW'(bus.o_ready),   RW'(0));
    checkOutput("rst_row",     bus.o_row,          '0);
    checkOutput("rst_row_en",  RW'(bus.o_row_en),  RW'(0));
    checkOutput("rst_row_idx", RW'(bus.o_row_idx), RW'(0));
    i_Reset = 1'b1;
    @(negedge i_clk);
    checkOutput("ready_rise",  RW'(bus.o_ready),   RW'(1));

    for (int i = 0; i < NV; i++) applyStimulus(vec[i].base, vec[i].gaps, 256);
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    waitReady();

    checkOutput("pulse_count", RW'(pulse_cyc.size()), RW'(16 * NV));
    for (int i = 0; i < NV; i++) begin
      p = 16 * i;
      for (int r = 0; r < 16; r++) begin
        checkOutput($sformatf("v%0d_row%0d", i, r), pulse_row[p + r], model_row(vec[i].base, r));
        checkOutput($sformatf("v%0d_idx%0d", i, r), RW'(pulse_idx[p + r]), RW'(r));
      end
      checkOutput($sformatf("v%0d_probe", i), pulse_row[p + vec[i].probe], vec[i].exp_row);
      checkDrain($sformatf("v%0d", i), pulse_cyc[p + 15]);
      if (i > 0 && !vec[i].gaps)
        checkOutput($sformatf("v%0d_b2b", i), RW'(pulse_cyc[p] - pulse_cyc[p - 1]), RW'(33));
    end

    applyStimulus(8'h50, 1'b0, 40);
    doReset();
    applyStimulus(8'h00, 1'b0, 256);
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    waitReady();
    checkOutput("rstmid_count", RW'(pulse_cyc.size()), RW'(16));
    checkOutput("rstmid_row0",  pulse_row[0], 128'h000102030405060708090A0B0C0D0E0F);
    checkOutput("rstmid_idx0",  RW'(pulse_idx[0]), RW'(0));
    checkOutput("rstmid_row15", pulse_row[15], 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);

`ifdef TPFEED_FLUSH_EN
    doReset();
    applyStimulus(8'h01, 1'b0, 20);
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b1;
    @(negedge i_clk);
    bus.i_flush = 1'b0;
    waitReady();
    checkOutput("flush_count", RW'(pulse_cyc.size()), RW'(16));
    checkOutput("flush_row0",  pulse_row[0], 128'h0102030405060708090A0B0C0D0E0F10);
    checkOutput("flush_row1",  pulse_row[1], 128'h11121314000000000000000000000000);
    checkOutput("flush_row2",  pulse_row[2], '0);
    checkOutput("flush_row15", pulse_row[15], '0);
    checkOutput("flush_idx15", RW'(pulse_idx[15]), RW'(15));
    checkDrain("flush", pulse_cyc[15]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/tpmem_row_feeder.md
# tpmem_row_feeder

Write-side sequencer for the 16x16 transpose memory in the 2-D transform datapath. Accepts a serial stream of BW-bit samples in raster order, packs each 16 samples into one row vector, and issues 16 single-cycle row writes per block. After each block it withholds upstream ready for exactly the interval in which the transpose memory streams out its 16 columns, so a row write never lands during a column read.

## Interface
- BW, 8, sample width in bits
- i_clk  in  1  rising-edge clock
- i_Reset  in  1  reset; one clock; reset is asynchronous and active-low
- i_valid  in  1  upstream sample valid
- i_sample  in  BW  upstream sample
- o_ready  out  1  sample accepted on any edge where i_valid && o_ready
- o_row  out  16*BW  packed row to the transpose memory data input
- o_row_en  out  1  one-cycle row write strobe to the transpose memory enable
- o_row_idx  out  4  index of the row currently on o_row (debug/verification)

## Operation
- Packing: sample k of a row (k=0..15) goes to o_row[(16-k)*BW-1:(15-k)*BW]; sample 0 occupies the top lane.
- Lane counter (4 b) advances per accepted sample and wraps 15->0. On the wrap, the packed row is copied to the o_row register and o_row_en pulses on the next cycle. The pack register is independent, so the next row's samples are accepted without a bubble.
- Row counter (4 b) advances on each o_row_en; o_row_idx equals the row counter value during the pulse.
- FSM states: FILL, LAST, DRAIN.
  - FILL: o_ready=1.
  - FILL->LAST: on acceptance of the 256th sample (lane 15, row 15).
  - LAST: o_ready=0; o_row_en pulses with row 15.
  - LAST->DRAIN: unconditionally after one cycle; drain counter loaded to 0.
  - DRAIN: o_ready=0 for exactly 16 cycles.
  - DRAIN->FILL: when drain counter reaches 15; lane, row and drain counters are then all 0.
- Values: o_row holds the last issued row between pulses. Outside LAST/DRAIN, o_row_en is 0 except on the cycle after a lane wrap.
- i_valid while o_ready=0 is ignored; no sample is lost or duplicated.
- Reset mid-block: partial row and counters are discarded; the next accepted sample is lane 0 of row 0.

## Timing
- Reset values: o_ready=0, o_row=0, o_row_en=0, o_row_idx=0, state FILL, all counters 0. o_ready rises on the first clock edge after i_Reset deasserts.
- Latency: 16th sample of a row accepted at cycle t -> o_row valid and o_row_en=1 at cycle t+1.
- Throughput: one sample per cycle for the 256 samples of a block.
- Drain interval: o_row_en high for the last row at cycle T. o_ready=0 for cycles T..T+16. o_ready=1 at T+17. The earliest next-block o_row_en is T+33.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- TPFEED_FLUSH_EN defined: adds input port i_flush (1 bit), sampled only when o_ready=1.
  - On a flush edge, a sample on i_valid in the same cycle is accepted first.
  - Unfilled lanes of the current row are zero-filled, and that row is issued on the next cycle.
  - Remaining rows up to row 15 are then issued as all-zero rows, one per cycle; the final row takes the LAST slot, then DRAIN.
  - If the current row has no samples but row>0, only all-zero rows row..15 are issued.
  - Flush with lane=0 and row=0 is a no-op.
  - o_ready=0 from the flush edge until DRAIN ends.
- TPFEED_FLUSH_EN undefined: no i_flush port. A partial block is held indefinitely until completed by further samples.

## Structure
- Shared package tpmem_pkg: N=16, LOG2N=4, FSM state enum (FILL, LAST, DRAIN, plus PAD under TPFEED_FLUSH_EN), lane-slice helper function.
- Sub-module tpmem_row_packer: lane counter, pack register, row register and wrap strobe. The top level holds the FSM, row counter and drain counter.

## Test plan
- Reset, then stream samples 0x00..0xFF with i_valid held high -> 16 pulses; row r equals {16r, 16r+1, ..., 16r+15}, MSB lane first; o_ready low for 17 cycles starting at the row-15 pulse.
- During DRAIN, drive i_valid=1 with sample 0xAA -> not accepted; next block's row 0 lane 0 equals the first sample presented after o_ready rises.
- Random i_valid gaps (50% duty) over one block -> row contents and order identical to the gapless case; exactly 16 pulses.
- Assert i_Reset after 40 samples, then stream 0x00..0xFF -> first pulse is row 0 = 0x00..0x0F; no stale data.
- Two back-to-back blocks -> second block's first pulse exactly 33 cycles after the first block's row-15 pulse.
- With TPFEED_FLUSH_EN: 20 samples 0x01..0x14 then i_flush -> row 1 = {0x11..0x14, 12 zeros}; rows 2..15 are zero; then 16-cycle DRAIN.
